mmio_uart_tx_buffered: RTL and testbench

//  MMIO responder for the UART transmit slot behind the MMIO controller.
//  - Accepts controller requests over the req/resp handshake.
//  - Buffers written bytes in a FIFO and serialises them as 8N1 on uart_tx.
//  - Reads return TX status or the baud divisor.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx_buffered.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_tx_buffered.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO UART transmit slot.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmio_pkg;

    // Register offsets within the slot; only bit [2] is decoded
    localparam logic [31:0] UART_TX_OFF_DATA = 32'h0000_0000;
    localparam logic [31:0] UART_TX_OFF_DIV  = 32'h0000_0004;

    // STATUS register bit positions
    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EMPTY     = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // A divisor below 2 cannot give a sensible bit period, so it is clamped
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and count.
// Latency: a push is visible on pop_dat/empty one cycle later; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign pop_dat = mem[rptr_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next pointer values
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mmio_uart_tx_buffered.sv
// MMIO responder that queues written bytes and sends them 8N1 on uart_tx.
// Latency: read data one cycle after accept; a byte written to an idle unit starts its start bit two cycles later.
// Backpressure: DATA writes stall while the FIFO is full; reads stall while a response is being presented.
module mmio_uart_tx_buffered
    import mmio_pkg::*;
#(
    parameter int FMAX_MHz = 27,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        uart_tx
);
    localparam int          DIV_DEFAULT = FMAX_MHz * 1_000_000 / BAUD;
    localparam logic [15:0] DIV_RST     = 16'(DIV_DEFAULT);
    localparam int          CW          = $clog2(DEPTH) + 1;

    logic            is_div, is_data, accept, push, pop, last;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      pop_dat;
    logic [31:0]     status;
    logic            unused_bits;

    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic [15:0]     div_q, div_d;
    tx_state_t       state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [15:0]     fdiv_q, fdiv_d;
    logic            tx_q, tx_d;

    assign is_div      = (req_addr[2] == UART_TX_OFF_DIV[2]);
    assign is_data     = (req_addr[2] == UART_TX_OFF_DATA[2]);
    assign req_ready   = req_wen ? !(is_data && fifo_full) : !resp_valid_q;
    assign accept      = req_valid && req_ready;
    assign push        = accept && req_wen && is_data;
    assign last        = (cnt_q == fdiv_q - 16'd1);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign uart_tx     = tx_q;
    assign unused_bits = ^{req_addr[31:3], req_addr[1:0], req_wdata[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (req_wdata[7:0]),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // STATUS word assembled from live FIFO/FSM state
    always_comb begin
        status                              = '0;
        status[STATUS_BUSY]                 = !fifo_empty || (state_q != TX_IDLE);
        status[STATUS_FULL]                 = fifo_full;
        status[STATUS_EMPTY]                = fifo_empty;
        status[STATUS_COUNT_LSB +: 8]       = 8'(fifo_count);
    end

    // Register writes and the one-cycle read response
    always_comb begin
        div_d        = div_q;
        resp_valid_d = accept && !req_wen;
        resp_rdata_d = resp_rdata_q;
        if (accept && req_wen && is_div) div_d = clamp_div(req_wdata[15:0]);
        if (resp_valid_d) resp_rdata_d = is_div ? {16'b0, div_q} : status;
    end

    // TX FSM: the divisor is latched per frame so a mid-frame write waits for the next start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        fdiv_d  = fdiv_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = pop_dat;
                    fdiv_d  = div_q;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (last) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State registers; reset aborts any frame and drives the line high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            div_q        <= DIV_RST;
            state_q      <= TX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            fdiv_q       <= DIV_RST;
            tx_q         <= 1'b1;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            div_q        <= div_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            fdiv_q       <= fdiv_d;
            tx_q         <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx_buffered.sv
// Directed bench for mmio_uart_tx_buffered at 27 MHz / 115200 baud (div 234).
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_uart_tx_buffered;

    logic        clk;
    logic        rst_n;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        uart_tx;

    int total;
    int bad;

    mmio_uart_tx_buffered #(.FMAX_MHz(27), .BAUD(115200), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_ready  (req_ready),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .uart_tx    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tbyte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 6000) begin
            tick();
            #1;
            n++;
        end
        if (n >= 6000) chk("wr_ready_timeout", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = addr;
        #1;
        chk("rd_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("rd_vld", {31'b0, resp_valid}, 32'd1);
        data = resp_rdata;
        tick();
        chk("rd_pulse", {31'b0, resp_valid}, 32'd0);
    endtask

    // Checks one frame; the current cycle is cycle 'skip' of the start bit
    task automatic check_frame(input logic [7:0] b, input int div, input int skip, input string tag);
        logic exp;
        logic obs;
        for (int k = 0; k < 10; k++) begin
            exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            obs = exp;
            for (int c = (k == 0) ? skip : 0; c < div; c++) begin
                if (uart_tx !== exp && obs === exp) obs = uart_tx;
                tick();
            end
            total++;
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s byte=0x%02h bit%0d observed=%b expected=%b", tag, b, k, obs, exp);
            end
        end
    endtask

    task automatic wait_start(output int n, input int bound);
        n = 0;
        while (uart_tx !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
    endtask

    logic [31:0] rd;
    int          n;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) tick();
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: idle status/divisor, then a single 0x55 frame
        do_read(32'h0, rd);
        chk("t1_status_idle", rd, 32'h0000_0004);
        do_read(32'h4, rd);
        chk("t1_div_reset", rd, 32'd234);
        do_write(32'h0, 32'h0000_0055);
        chk("t1_no_bypass_n1", {31'b0, uart_tx}, 32'd1);
        tick();
        check_frame(8'h55, 234, 0, "t1_frame");
        do_read(32'h0, rd);
        chk("t1_status_after", rd, 32'h0000_0004);

        // 2: fill the FIFO behind an in-flight frame, then one more write
        do_write(32'h0, 32'h0000_00A5);
        for (int i = 0; i < 16; i++) do_write(32'h0, {24'b0, tbyte(i)});
        do_read(32'h0, rd);
        chk("t2_status_full", rd, 32'h0000_1003);
        req_valid = 1'b0;
        req_wen   = 1'b1;
        req_addr  = 32'h4;
        #1;
        chk("t2_div_ready_when_full", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h0;
        req_wdata = {24'b0, tbyte(16)};
        #1;
        chk("t2_full_stall", {31'b0, req_ready}, 32'd0);
        n = 0;
        while (req_ready !== 1'b1 && n < 5000) begin
            tick();
            #1;
            n++;
        end
        chk("t2_stall_release", {31'b0, req_ready}, 32'd1);
        chk("t2_pop_before_accept", {31'b0, uart_tx}, 32'd0);
        tick();
        req_valid = 1'b0;
        req_wen   = 1'b0;
        check_frame(tbyte(0), 234, 1, "t2_frame");
        for (int i = 1; i < 17; i++) begin
            wait_start(n, 3000);
            chk("t2_gap", n, 32'd1);
            check_frame(tbyte(i), 234, 0, "t2_frame");
        end

        // 3: divisor clamp, then a mid-frame divisor change
        do_write(32'h4, 32'h0000_0001);
        do_read(32'h4, rd);
        chk("t3_div_clamp", rd, 32'h0000_0002);
        do_write(32'h4, 32'd234);
        do_write(32'h0, 32'h0000_003C);
        do_write(32'h0, 32'h0000_00C3);
        repeat (50) tick();
        do_write(32'h4, 32'h0000_000A);
        check_frame(8'h3C, 234, 51, "t3_old_rate");
        wait_start(n, 100);
        chk("t3_gap", n, 32'd1);
        check_frame(8'hC3, 10, 0, "t3_new_rate");
        do_read(32'h4, rd);
        chk("t3_div_read", rd, 32'h0000_000A);

        // 4: STATUS read during DATA with three bytes queued
        do_write(32'h0, 32'h0000_0000);
        do_write(32'h0, 32'h0000_0011);
        do_write(32'h0, 32'h0000_0022);
        do_write(32'h0, 32'h0000_0033);
        repeat (10) tick();
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        #1;
        chk("t4_rd_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("t4_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("t4_status", resp_rdata, 32'h0000_0301);
        tick();
        chk("t4_resp_pulse", {31'b0, resp_valid}, 32'd0);
        chk("t4_rdata_held", resp_rdata, 32'h0000_0301);

        // 5: asynchronous reset in the middle of a data bit
        chk("t5_tx_low_before", {31'b0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_tx_async", {31'b0, uart_tx}, 32'd1);
        chk("t5_rdata_rst", resp_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_tx_idle", {31'b0, uart_tx}, 32'd1);
        do_read(32'h0, rd);
        chk("t5_fifo_empty", rd, 32'h0000_0004);
        do_read(32'h4, rd);
        chk("t5_div_reset", rd, 32'd234);

        // 6: simultaneous push and pop at count 5, then upper data bits ignored
        do_write(32'h4, 32'h0000_0004);
        for (int i = 0; i < 6; i++) do_write(32'h0, {24'b0, tbyte(i + 20)});
        repeat (36) tick();
        do_write(32'h0, {24'b0, tbyte(26)});
        do_read(32'h0, rd);
        chk("t6_push_pop_count", rd, 32'h0000_0501);
        n = 0;
        rd = '0;
        while (rd !== 32'h0000_0004 && n < 300) begin
            do_read(32'h0, rd);
            n++;
        end
        chk("t6_drain", rd, 32'h0000_0004);
        do_write(32'h0, 32'hABCD_12FF);
        chk("t6_no_bypass", {31'b0, uart_tx}, 32'd1);
        tick();
        check_frame(8'hFF, 4, 0, "t6_low_byte");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
